// File: rtl/kavach_temp_pkg.sv
// Shared types and constants for the Kavach thermal-sampling path.
package kavach_temp_pkg;

  localparam int unsigned TEMP_ADC_WIDTH = 12;
  // Guard bits so a burst of up to 8 full-scale codes fits the accumulator.
  localparam int unsigned TEMP_ACC_GUARD = 3;

  localparam logic [1:0] OSR_1 = 2'd0;
  localparam logic [1:0] OSR_2 = 2'd1;
  localparam logic [1:0] OSR_4 = 2'd2;
  localparam logic [1:0] OSR_8 = 2'd3;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_TICK,
    S_START,
    S_CONVERT,
    S_EMIT
  } sampler_state_t;

  function automatic logic [2:0] burst_last(input logic [1:0] osr);
    case (osr)
      OSR_1:   return 3'd0;
      OSR_2:   return 3'd1;
      OSR_4:   return 3'd3;
      OSR_8:   return 3'd7;
      default: return 3'd7;
    endcase
  endfunction

endpackage

// File: rtl/kavach_period_timer.sv
// Free-running period counter producing a one-cycle tick every max(period_cfg,1) cycles.
module kavach_period_timer #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             run,
  input  logic [WIDTH-1:0] period_cfg,
  output logic             tick
);

  logic [WIDTH-1:0] count;
  logic [WIDTH-1:0] last;

  // A limit below the current count is not caught early: the count wraps naturally.
  always_comb begin
    last = (period_cfg == '0) ? '0 : period_cfg - 1'b1;
    tick = run && (count == last);
  end

  always_ff @(posedge clk) begin
    if (rst || !run || tick) begin
      count <= '0;
    end else begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/kavach_temp_sampler.sv
// Paces thermal-diode SAR conversions, averages bursts of 1/2/4/8 and strobes the result.
module kavach_temp_sampler
  import kavach_temp_pkg::*;
#(
  parameter int unsigned ADC_WIDTH    = TEMP_ADC_WIDTH,
  parameter int unsigned PERIOD_WIDTH = 16,
  parameter logic [7:0]  CONV_TIMEOUT = 8'd200,
  parameter int unsigned ACC_WIDTH    = ADC_WIDTH + TEMP_ACC_GUARD
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    enable,
  input  logic [PERIOD_WIDTH-1:0] period_cfg,
  input  logic [1:0]              osr_cfg,
  input  logic                    err_clr,
  output logic                    adc_start,
  input  logic                    adc_done,
  input  logic [ADC_WIDTH-1:0]    adc_data,
  output logic [ADC_WIDTH-1:0]    temp_sample,
  output logic                    sample_valid,
  output logic                    adc_timeout_err,
  output logic                    overrun_err,
  output logic                    sampler_busy
);

  sampler_state_t       state;
  logic                 run;
  logic                 tick;
  logic [ACC_WIDTH-1:0] acc;
  logic [ACC_WIDTH-1:0] acc_next;
  logic [ADC_WIDTH-1:0] avg;
  logic [2:0]           conv_cnt;
  logic [1:0]           osr_q;
  logic [7:0]           tmo_cnt;

  assign run = enable && (state != S_IDLE);

  kavach_period_timer #(
    .WIDTH(PERIOD_WIDTH)
  ) u_timer (
    .clk        (clk),
    .rst        (rst),
    .run        (run),
    .period_cfg (period_cfg),
    .tick       (tick)
  );

  // The averaged code is formed from the sum including the final conversion,
  // so it can be registered together with the sample_valid strobe.
  always_comb begin
    acc_next = acc + ACC_WIDTH'(adc_data);
    avg      = ADC_WIDTH'(acc_next >> osr_q);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= S_IDLE;
      acc             <= '0;
      conv_cnt        <= '0;
      osr_q           <= '0;
      tmo_cnt         <= '0;
      adc_start       <= 1'b0;
      temp_sample     <= '0;
      sample_valid    <= 1'b0;
      adc_timeout_err <= 1'b0;
      overrun_err     <= 1'b0;
      sampler_busy    <= 1'b0;
    end else begin
      adc_start    <= 1'b0;
      sample_valid <= 1'b0;

      if (err_clr) begin
        adc_timeout_err <= 1'b0;
        overrun_err     <= 1'b0;
      end
      if (tick && (state inside {S_START, S_CONVERT, S_EMIT})) begin
        overrun_err <= 1'b1;
      end

      if (!enable) begin
        state        <= S_IDLE;
        sampler_busy <= 1'b0;
      end else begin
        case (state)
          S_IDLE: state <= S_WAIT_TICK;
          S_WAIT_TICK: begin
            if (tick) begin
              acc          <= '0;
              conv_cnt     <= '0;
              osr_q        <= osr_cfg;
              adc_start    <= 1'b1;
              sampler_busy <= 1'b1;
              state        <= S_START;
            end
          end
          S_START: begin
            tmo_cnt <= '0;
            state   <= S_CONVERT;
          end
          S_CONVERT: begin
            // A done arriving on the expiry cycle takes priority over the timeout.
            if (adc_done) begin
              acc <= acc_next;
              if (conv_cnt == burst_last(osr_q)) begin
                temp_sample  <= avg;
                sample_valid <= 1'b1;
                state        <= S_EMIT;
              end else begin
                conv_cnt  <= conv_cnt + 3'd1;
                adc_start <= 1'b1;
                state     <= S_START;
              end
            end else if (tmo_cnt == CONV_TIMEOUT - 8'd1) begin
              adc_timeout_err <= 1'b1;
              sampler_busy    <= 1'b0;
              state           <= S_WAIT_TICK;
            end else begin
              tmo_cnt <= tmo_cnt + 8'd1;
            end
          end
          S_EMIT: begin
            sampler_busy <= 1'b0;
            state        <= S_WAIT_TICK;
          end
          default: begin
            sampler_busy <= 1'b0;
            state        <= S_IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_kavach_temp_sampler.sv
// Directed bench for kavach_temp_sampler with a burst-level reference model and per-cycle compare.
module tb_kavach_temp_sampler;

  localparam int AW  = 12;
  localparam int PW  = 16;
  localparam int TMO = 200;

  logic          clk = 1'b0;
  logic          rst;
  logic          enable;
  logic [PW-1:0] period_cfg;
  logic [1:0]    osr_cfg;
  logic          err_clr;
  logic          adc_start;
  logic          adc_done;
  logic [AW-1:0] adc_data;
  logic [AW-1:0] temp_sample;
  logic          sample_valid;
  logic          adc_timeout_err;
  logic          overrun_err;
  logic          sampler_busy;

  always #5 clk = ~clk;

  kavach_temp_sampler #(
    .ADC_WIDTH    (AW),
    .PERIOD_WIDTH (PW),
    .CONV_TIMEOUT (8'd200)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .enable          (enable),
    .period_cfg      (period_cfg),
    .osr_cfg         (osr_cfg),
    .err_clr         (err_clr),
    .adc_start       (adc_start),
    .adc_done        (adc_done),
    .adc_data        (adc_data),
    .temp_sample     (temp_sample),
    .sample_valid    (sample_valid),
    .adc_timeout_err (adc_timeout_err),
    .overrun_err     (overrun_err),
    .sampler_busy    (sampler_busy)
  );

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // ADC responder controls (written by stimulus only)
  int            adc_lat   = 0;
  logic [AW-1:0] adc_fix   = '0;
  logic [AW-1:0] tab [8];
  int            tab_len   = 0;
  int            tab_gen   = 0;
  int            inj_cycle = -1;
  logic [AW-1:0] inj_data  = '0;

  // Observed events (written by compare process only)
  int n_start = 0, n_valid = 0, n_done = 0;
  int last_start = -1, last_valid = -1, prev_valid = -1, err_rise = -1;
  int dbl_start = 0;
  bit prev_start = 0, prev_tmo = 0;

  // Reference model: burst bookkeeping in plain integers
  bit m_on, m_burst, m_wait;
  int m_timer, m_waited, m_sum, m_got, m_need, m_shift;
  bit e_start, e_valid, e_tmo, e_ovr;
  int e_temp;
  bit armed = 0;

  function automatic void model_step();
    int lim;
    bit act, tk, ns, nv;
    if (rst) begin
      m_on = 0; m_burst = 0; m_wait = 0; m_timer = 0;
      e_start = 0; e_valid = 0; e_tmo = 0; e_ovr = 0; e_temp = 0;
      return;
    end
    lim = (period_cfg == '0) ? 1 : int'(period_cfg);
    act = m_on && enable;
    tk  = act && (m_timer == lim - 1);
    if (err_clr) begin e_tmo = 0; e_ovr = 0; end
    if (tk && m_burst) e_ovr = 1;
    ns = 0; nv = 0;
    if (!enable) begin
      m_on = 0; m_burst = 0; m_wait = 0;
    end else if (!m_on) begin
      m_on = 1;
    end else if (!m_burst) begin
      if (tk) begin
        m_burst = 1; m_need = 1 << osr_cfg; m_shift = int'(osr_cfg);
        m_got = 0; m_sum = 0; ns = 1;
      end
    end else if (e_valid) begin
      m_burst = 0;
    end else if (e_start) begin
      m_wait = 1; m_waited = 0;
    end else if (m_wait) begin
      if (adc_done) begin
        m_sum += int'(adc_data); m_got++; m_wait = 0;
        if (m_got == m_need) begin nv = 1; e_temp = m_sum >> m_shift; end
        else ns = 1;
      end else if (m_waited + 1 == TMO) begin
        e_tmo = 1; m_burst = 0; m_wait = 0;
      end else begin
        m_waited++;
      end
    end
    m_timer = !act ? 0 : (tk ? 0 : (m_timer + 1) % 65536);
    e_start = ns;
    e_valid = nv;
  endfunction

  initial begin : compare
    logic [16:0] act_v, exp_v;
    forever begin
      @(posedge clk);
      cyc++;
      model_step();
      if (rst) armed = 1;
      #1;
      if (armed) begin
        exp_v = {e_start, e_valid, e_tmo, e_ovr, m_burst, 12'(e_temp)};
        act_v = {adc_start, sample_valid, adc_timeout_err, overrun_err, sampler_busy, temp_sample};
        checks++;
        if (act_v !== exp_v) begin
          errors++;
          $display("FAIL cycle_%0d {start,valid,tmo,ovr,busy,temp}: got %h expected %h", cyc, act_v, exp_v);
        end
        if (adc_start) begin
          n_start++; last_start = cyc;
          if (prev_start) dbl_start++;
        end
        prev_start = adc_start;
        if (sample_valid) begin prev_valid = last_valid; last_valid = cyc; n_valid++; end
        if (adc_done) n_done++;
        if (adc_timeout_err && !prev_tmo) err_rise = cyc;
        prev_tmo = adc_timeout_err;
      end
    end
  end

  initial begin : adc_bfm
    int cd, idx, seen_gen;
    cd = 0; idx = 0; seen_gen = 0;
    adc_done = 1'b0;
    adc_data = '0;
    forever begin
      @(negedge clk);
      if (tab_gen != seen_gen) begin seen_gen = tab_gen; idx = 0; end
      adc_done = 1'b0;
      if (cd > 0) begin
        cd--;
        if (cd == 0) begin
          adc_done = 1'b1;
          if (idx < tab_len) begin adc_data = tab[idx]; idx++; end
          else adc_data = adc_fix;
        end
      end
      if (cyc == inj_cycle) begin adc_done = 1'b1; adc_data = inj_data; end
      if (adc_start && adc_lat > 0) cd = adc_lat;
    end
  end

  initial begin : watchdog
    #300000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  task automatic wait_valid(input int limit, input string name);
    int base, k;
    base = n_valid; k = 0;
    while (n_valid == base && k < limit) begin @(negedge clk); k++; end
    check(name, int'(n_valid != base), 1);
  endtask

  task automatic wait_start(input int limit, input string name);
    int base, k;
    base = n_start; k = 0;
    while (n_start == base && k < limit) begin @(negedge clk); k++; end
    check(name, int'(n_start != base), 1);
  endtask

  task automatic idle_cycle();
    enable  = 1'b0;
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
  endtask

  initial begin : stim
    int s_v, s_st, s_d, k;
    rst = 1'b1; enable = 1'b0; period_cfg = '0; osr_cfg = '0; err_clr = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_outputs", int'({adc_start, sample_valid, adc_timeout_err, overrun_err, sampler_busy, temp_sample}), 0);
    rst = 1'b0;

    // Basic pacing: period 10, single conversions, latency 5
    period_cfg = 16'd10; osr_cfg = 2'd0; adc_lat = 5; adc_fix = 12'h3E8; tab_len = 0; tab_gen++;
    s_v = n_valid; s_st = n_start;
    enable = 1'b1;
    repeat (60) @(negedge clk);
    check("basic_valid_count", n_valid - s_v, 5);
    check("basic_start_count", n_start - s_st, 5);
    check("basic_interval", last_valid - prev_valid, 10);
    check("basic_latency", last_valid - last_start, 6);
    check("basic_temp", int'(temp_sample), 'h3E8);
    check("basic_model_temp", e_temp, 'h3E8);
    check("basic_no_overrun", int'(overrun_err), 0);

    // Averaging: four codes 100,101,102,105 -> 408 >> 2 = 102
    idle_cycle();
    period_cfg = 16'd40; osr_cfg = 2'd2; adc_lat = 3;
    tab[0] = 12'd100; tab[1] = 12'd101; tab[2] = 12'd102; tab[3] = 12'd105; tab_len = 4; tab_gen++;
    s_st = n_start;
    enable = 1'b1;
    wait_valid(200, "avg_valid_seen");
    check("avg_temp", int'(temp_sample), 102);
    check("avg_model_temp", e_temp, 102);
    check("avg_start_count", n_start - s_st, 4);

    // Timeout: ADC never answers
    idle_cycle();
    period_cfg = 16'd300; osr_cfg = 2'd0; adc_lat = 0; tab_len = 0; tab_gen++;
    s_v = n_valid;
    enable = 1'b1;
    wait_start(400, "tmo_start_seen");
    k = 0;
    while (!adc_timeout_err && k < 300) begin @(negedge clk); k++; end
    check("tmo_flag", int'(adc_timeout_err), 1);
    check("tmo_latency", err_rise - last_start, TMO + 1);
    check("tmo_no_sample", n_valid - s_v, 0);
    check("tmo_busy_cleared", int'(sampler_busy), 0);
    adc_lat = 5; adc_fix = 12'h123;
    wait_valid(400, "tmo_restart_valid");
    check("tmo_restart_temp", int'(temp_sample), 'h123);
    check("tmo_flag_sticky", int'(adc_timeout_err), 1);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    check("tmo_flag_cleared", int'(adc_timeout_err), 0);

    // Overrun: period 4, conversion latency 10
    idle_cycle();
    period_cfg = 16'd4; adc_lat = 10; adc_fix = 12'h055;
    s_v = n_valid;
    enable = 1'b1;
    repeat (60) @(negedge clk);
    check("ovr_flag", int'(overrun_err), 1);
    check("ovr_valid_count", n_valid - s_v, 3);
    check("ovr_temp", int'(temp_sample), 'h055);

    // Abort after 2 of 8 conversions, then a full burst (mean 8028/8 truncates to 1003)
    idle_cycle();
    repeat (15) @(negedge clk);
    period_cfg = 16'd100; osr_cfg = 2'd3; adc_lat = 2;
    for (int i = 0; i < 8; i++) tab[i] = 12'(1000 + i);
    tab_len = 8; tab_gen++;
    s_v = n_valid; s_d = n_done;
    enable = 1'b1;
    k = 0;
    while (n_done - s_d < 2 && k < 300) begin @(negedge clk); k++; end
    check("abort_two_done", n_done - s_d, 2);
    enable = 1'b0;
    s_st = n_start;
    repeat (20) @(negedge clk);
    check("abort_no_start", n_start - s_st, 0);
    check("abort_no_valid", n_valid - s_v, 0);
    check("abort_idle_busy", int'(sampler_busy), 0);
    tab_gen++;
    s_st = n_start;
    enable = 1'b1;
    wait_valid(400, "rerun_valid_seen");
    check("rerun_start_count", n_start - s_st, 8);
    check("rerun_temp", int'(temp_sample), 1003);
    check("rerun_model_temp", e_temp, 1003);

    // Reset mid-CONVERT
    idle_cycle();
    period_cfg = 16'd5; osr_cfg = 2'd0; adc_lat = 0;
    enable = 1'b1;
    wait_start(50, "rst_start_seen");
    repeat (10) @(negedge clk);
    check("rst_pre_busy", int'(sampler_busy), 1);
    check("rst_pre_overrun", int'(overrun_err), 1);
    rst = 1'b1;
    @(negedge clk);
    check("rst_mid_outputs", int'({adc_start, sample_valid, adc_timeout_err, overrun_err, sampler_busy, temp_sample}), 0);
    rst = 1'b0; enable = 1'b0;
    @(negedge clk);

    // period_cfg = 0 behaves as 1: tick every cycle
    period_cfg = '0; adc_lat = 1; adc_fix = 12'h7FF;
    s_v = n_valid;
    enable = 1'b1;
    repeat (30) @(negedge clk);
    check("p0_overrun", int'(overrun_err), 1);
    check("p0_valid_count", n_valid - s_v, 7);
    check("p0_temp", int'(temp_sample), 'h7FF);

    // Stray adc_done while waiting for a tick
    idle_cycle();
    period_cfg = 16'd50; adc_lat = 2; adc_fix = 12'h200;
    enable = 1'b1;
    wait_valid(200, "stray_valid_seen");
    inj_data = 12'hFFF; inj_cycle = cyc + 3;
    s_v = n_valid; s_st = n_start;
    repeat (8) @(negedge clk);
    check("stray_no_valid", n_valid - s_v, 0);
    check("stray_no_start", n_start - s_st, 0);
    check("stray_temp_held", int'(temp_sample), 'h200);

    // adc_done on the timeout-expiry cycle: sample wins, no error
    idle_cycle();
    period_cfg = 16'd300; adc_lat = 0;
    enable = 1'b1;
    wait_start(400, "coin_start_seen");
    inj_data = 12'h0AB; inj_cycle = last_start + TMO;
    wait_valid(300, "coin_valid_seen");
    check("coin_latency", last_valid - last_start, TMO + 1);
    check("coin_temp", int'(temp_sample), 'h0AB);
    check("coin_no_tmo", int'(adc_timeout_err), 0);

    check("start_single_cycle", dbl_start, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
